// File: rtl/mem_responder_pkg.sv
// Shared types for the fixed-latency memory responder.
package mem_responder_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Single-port memory handshake between the core (master) and the responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_responder_be_sram.sv
// Word array with per-byte write enables and a registered, hold-until-next-read output.
module be_sram
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one request at a time, one-cycle mem_resp,
// byte-enable writes and a sticky protocol-violation flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  mem,
  input  logic            stall,
  output logic            req_error
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit              DIRECT   = (LATENCY == 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_wr;
  logic [29:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_resp;
  logic              r_err;

  logic              w_accept;
  logic              w_direct;
  logic              w_done;
  logic              w_mismatch;
  logic              w_we;
  logic              w_re;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^mem.mem_address[1:0];

  assign w_accept = (r_state == IDLE) && (mem.mem_read || mem.mem_write);
  assign w_direct = DIRECT && w_accept;
  // Countdown is loaded with LATENCY-1 so RESP lands LATENCY cycles after the request cycle.
  assign w_done   = (r_state == BUSY) && !stall && (r_cnt <= CNT_W'(1));

  assign w_mismatch = (r_state == BUSY) &&
                      ((mem.mem_write != r_is_wr) ||
                       (mem.mem_read  != !r_is_wr) ||
                       (mem.mem_address[31:2] != r_addr) ||
                       (mem.mem_wdata != r_wdata) ||
                       (mem.mem_byte_enable != r_be));

  // Array access happens at the edge entering RESP; gated by reset so an abandoned write never lands.
  assign w_we    = rst && ((w_done && r_is_wr) || (w_direct && mem.mem_write));
  assign w_re    = rst && ((w_done && !r_is_wr) || (w_direct && !mem.mem_write));
  assign w_idx   = w_direct ? mem.mem_address[IDX_W+1:2] : r_addr[IDX_W-1:0];
  assign w_wdata = w_direct ? mem.mem_wdata : r_wdata;
  assign w_be    = w_direct ? mem.mem_byte_enable : r_be;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      if ((w_accept && mem.mem_read && mem.mem_write) || w_mismatch) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_wr <= mem.mem_write;
            r_addr  <= mem.mem_address[31:2];
            r_wdata <= mem.mem_wdata;
            r_be    <= mem.mem_byte_enable;
            if (DIRECT) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (!stall) begin
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  be_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .i_be   (w_be),
    .o_rdata(mem.mem_rdata)
  );

  assign mem.mem_resp = r_resp;
  assign req_error    = r_err;

endmodule
